lampfpu_round_pack: RTL
=======================

Name: lampfpu_round_pack

Overview:
- Back end of the bf16 add/sub datapath. Consumes the unrounded post-normalised result {sign, exponent, 12-bit significand with G/R/S} plus the round, overflow and underflow qualifiers.
- Rounds the result, handles significand carry-out and exponent overflow, and packs a 16-bit bf16 word.
- 2-stage pipeline with valid/ready handshake and sticky IEEE exception flags.
- Sits between the add/sub core and the FPU result/writeback port.

Parameters:
- E_DW, 8, exponent width.
- F_DW, 7, stored fraction width. Input significand is F_DW+5 bits; result is 1+E_DW+F_DW bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- valid_i  in  1  input result valid.
- ready_o  out  1  block can accept input.
- s_res_i  in  1  sign.
- e_res_i  in  E_DW  biased exponent (0 = zero/denormal).
- f_res_i  in  F_DW+5  significand: [F_DW+4] carry (always 0), [F_DW+3] hidden, [F_DW+2:3] fraction, [2] G, [1] R, [0] S.
- isToRound_i  in  1  0 = NaN/Inf special, pass through unrounded.
- isOverflow_i  in  1  upstream overflow.
- isUnderflow_i  in  1  upstream underflow.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- result_o  out  1+E_DW+F_DW  packed {s, e, frac}.
- flags_o  out  3  sticky {OF, UF, NX}.
- clear_flags_i  in  1  clear sticky flags.

Behaviour:
- Reset: valid_o=0, result_o=0, flags_o=0; both pipeline valid bits cleared.
  - Reset mid-operation discards in-flight data.
  - ready_o=1 the cycle after rst deasserts.
- Pipeline enable: en = ~valid_o | ready_i.
  - ready_o = en, combinational.
  - Input transfer occurs on valid_i & ready_o.
  - Stage 1 and stage 2 advance only when en=1.
  - When en=0, result_o and valid_o hold stable.
  - Latency: 2 cycles from input transfer to valid_o. Throughput: 1 result per cycle.
- Stage 1 (registered):
  - lsb=f[3], g=f[2], r=f[1], st=f[0].
  - inexact = isToRound_i & (g|r|st).
  - RNE: rnd_up = isToRound_i & g & (r|st|lsb).
  - Registers s, e, {hidden, frac}, rnd_up, inexact, isToRound, ovf, unf.
- Stage 2 (registered):
  - mant = {hidden, frac} + rnd_up, F_DW+2 bits wide.
  - Carry-out: e+1, frac=0.
  - e=0 and mant hidden bit becomes 1 (denormal rounds up to normal): e=1.
  - Resulting e = 2^E_DW-1, or ovf set: result = ±Inf (e all ones, frac 0); OF=1, NX=1.
  - isToRound=0: result = {s, e, f[F_DW+2:3]} unchanged; no flags.
  - UF = unf | (final e==0 & inexact & frac≠0 before rounding). NX = inexact | OF.
- Flags:
  - On each output transfer (valid_o & ready_i), flags_o |= result flags.
  - clear_flags_i alone: flags_o ← 0 next cycle.
  - Clear coincident with a transfer: flags_o ← that transfer's flags only.
- Pipeline stage 2 holds the result and its flags until the transfer.

Optional Feature:
- Macro: LAMP_FPU_ROUND_MODES_EN.
- Defined:
  - Adds input port rnd_mode_i [1:0], sampled in stage 1 with the data.
  - Modes: 00 RNE, 01 RTZ (rnd_up=0), 10 RDN (rnd_up = s & inexact), 11 RUP (rnd_up = ~s & inexact).
  - Overflow under RTZ, RDN with s=0, or RUP with s=1 yields ±max finite (e=0xFE, frac=0x7F for defaults); OF=1, NX=1.
- Undefined: port absent; RNE only; overflow always yields ±Inf.

Test Plan:
- Tie, even: s=0, e=0x7F, f=0_1_0000000_100, isToRound=1 → result 0x3F80, NX set, 2-cycle latency.
- Tie, odd: e=0x7F, f=0_1_0000001_100 → 0x3F82. Carry: f=0_1_1111111_110 → 0x4000.
- Overflow: e=0xFE, f=0_1_1111111_110 → 0x7F80, flags_o=3'b101. With macro, rnd_mode=01 → 0x7F7F.
- Special pass-through: isToRound=0, s=0, e=0xFF, f=0_1_1000000_000, G/R/S=0 → 0x7FC0, flags unchanged.
  - Assert clear_flags_i together → flags_o=0.
- Backpressure: 4 back-to-back inputs with ready_i low for 3 cycles → ready_o low while valid_o=1.
  - All 4 results emerge in order, none lost or duplicated; result_o stable while stalled.
- Reset mid-operation: assert rst with 2 results in flight → valid_o=0 and flags_o=0 immediately.
  - No stale result appears after rst deasserts.

Source files
------------

// File: rtl/lampfpu_round_pack.sv
// bf16 round-and-pack back end: 2-stage pipeline that rounds the post-normalised add/sub result,
// packs {s, e, frac} and keeps sticky {OF, UF, NX}. Define LAMP_FPU_ROUND_MODES_EN for RTZ/RDN/RUP.
module lampfpu_round_pack #(
  parameter int E_DW = 8,
  parameter int F_DW = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 s_res_i,
  input  logic [E_DW-1:0]      e_res_i,
  input  logic [F_DW+4:0]      f_res_i,
  input  logic                 isToRound_i,
  input  logic                 isOverflow_i,
  input  logic                 isUnderflow_i,
`ifdef LAMP_FPU_ROUND_MODES_EN
  input  logic [1:0]           rnd_mode_i,
`endif
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [E_DW+F_DW:0]   result_o,
  output logic [2:0]           flags_o,
  input  logic                 clear_flags_i
);

  localparam logic [E_DW:0] E_MAX = {1'b0, {E_DW{1'b1}}};
  localparam logic [E_DW:0] E_ONE = {{E_DW{1'b0}}, 1'b1};

  // Handshake: a beat moves on valid & ready. The whole pipe advances only when the output
  // register is empty or being drained (en), so ready_o is en and output data holds while stalled.
  logic en;
  logic xfer;
  assign en      = ~valid_o | ready_i;
  assign ready_o = en;
  assign xfer    = valid_o & ready_i;

  // Stage 1 decode
  logic lsb, g, r, st;
  logic inexact_d, rnd_up_d;
  assign lsb       = f_res_i[3];
  assign g         = f_res_i[2];
  assign r         = f_res_i[1];
  assign st        = f_res_i[0];
  assign inexact_d = isToRound_i & (g | r | st);

`ifdef LAMP_FPU_ROUND_MODES_EN
  always_comb begin
    rnd_up_d = 1'b0;
    case (rnd_mode_i)
      2'b00:   rnd_up_d = isToRound_i & g & (r | st | lsb);
      2'b01:   rnd_up_d = 1'b0;
      2'b10:   rnd_up_d = s_res_i & inexact_d;
      default: rnd_up_d = ~s_res_i & inexact_d;
    endcase
  end
`else
  assign rnd_up_d = isToRound_i & g & (r | st | lsb);
`endif

  logic              v1, s1, rnd_up1, inexact1, to_round1, ovf1, unf1;
  logic [E_DW-1:0]   e1;
  logic [F_DW+1:0]   m1;
`ifdef LAMP_FPU_ROUND_MODES_EN
  logic [1:0]        mode1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      s1        <= 1'b0;
      e1        <= '0;
      m1        <= '0;
      rnd_up1   <= 1'b0;
      inexact1  <= 1'b0;
      to_round1 <= 1'b0;
      ovf1      <= 1'b0;
      unf1      <= 1'b0;
`ifdef LAMP_FPU_ROUND_MODES_EN
      mode1     <= 2'b00;
`endif
    end else if (en) begin
      v1        <= valid_i;
      s1        <= s_res_i;
      e1        <= e_res_i;
      m1        <= f_res_i[F_DW+4:3];
      rnd_up1   <= rnd_up_d;
      inexact1  <= inexact_d;
      to_round1 <= isToRound_i;
      ovf1      <= isOverflow_i;
      unf1      <= isUnderflow_i;
`ifdef LAMP_FPU_ROUND_MODES_EN
      mode1     <= rnd_mode_i;
`endif
    end
  end

  // Stage 2: increment, carry-out / denormal promotion, overflow and packing
  logic [F_DW+1:0]    mant;
  logic [E_DW:0]      e_sum;
  logic [F_DW-1:0]    frac_rnd;
  logic               of_d, uf_d, sat;
  logic [E_DW+F_DW:0] res_d;
  logic [2:0]         res_flags_d;

`ifdef LAMP_FPU_ROUND_MODES_EN
  assign sat = (mode1 == 2'b01) | ((mode1 == 2'b10) & ~s1) | ((mode1 == 2'b11) & s1);
`else
  assign sat = 1'b0;
`endif

  always_comb begin
    mant        = m1 + {{(F_DW+1){1'b0}}, rnd_up1};
    e_sum       = {1'b0, e1};
    frac_rnd    = mant[F_DW-1:0];
    if (mant[F_DW+1]) begin
      e_sum    = {1'b0, e1} + E_ONE;
      frac_rnd = '0;
    end else if ((e1 == '0) && mant[F_DW]) begin
      e_sum    = E_ONE;
    end
    of_d        = to_round1 & (ovf1 | (e_sum >= E_MAX));
    uf_d        = unf1 | ((e_sum == '0) & inexact1 & (|m1[F_DW-1:0]));
    res_d       = {s1, e1, m1[F_DW-1:0]};
    res_flags_d = 3'b000;
    if (to_round1) begin
      if (of_d) begin
        if (sat) res_d = {s1, {(E_DW-1){1'b1}}, 1'b0, {F_DW{1'b1}}};
        else     res_d = {s1, {E_DW{1'b1}}, {F_DW{1'b0}}};
        res_flags_d = {1'b1, unf1, 1'b1};
      end else begin
        res_d       = {s1, e_sum[E_DW-1:0], frac_rnd};
        res_flags_d = {1'b0, uf_d, inexact1};
      end
    end
  end

  logic [2:0] res_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o   <= 1'b0;
      result_o  <= '0;
      res_flags <= 3'b000;
    end else if (en) begin
      valid_o   <= v1;
      result_o  <= res_d;
      res_flags <= res_flags_d;
    end
  end

  // A clear coinciding with a transfer keeps only that transfer's flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_o <= 3'b000;
    end else if (clear_flags_i) begin
      flags_o <= xfer ? res_flags : 3'b000;
    end else if (xfer) begin
      flags_o <= flags_o | res_flags;
    end
  end

endmodule
